// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_pkg
// Description : Shared types and helpers for the pipeline stage register.
//               Holds the default bubble-counter width, an example stage
//               payload layout and the occupancy encoding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_skid_pkg;

    // Default width of the per-stage bubble counter.
    localparam int STAGE_CNT_W = 16;

    // Occupancy encoding as reported on the occupancy port.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Example MEM/WB payload; wrappers flatten such structs onto DATA_W.
    typedef struct packed {
        logic [63:0] alu_result;
        logic [63:0] mem_rdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mw_payload_t;

    // The skid entry is only ever valid while the main entry is valid,
    // so the count is derived from the two valid bits directly.
    function automatic occ_e occ_count(input logic main_v, input logic skid_v);
        if (skid_v) begin
            return OCC_TWO;
        end else if (main_v) begin
            return OCC_ONE;
        end
        return OCC_EMPTY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline stage register with valid/ready handshake and an
//               optional 2-entry skid buffer, flush, sticky halt and a
//               saturating bubble counter.
// Ports       : CLK/RST          - clock, synchronous active-high reset
//               flush            - drop all held entries
//               in_valid/in_ready/in_data/in_halt     - upstream side
//               out_valid/out_ready/out_data/out_halt - downstream side
//               occupancy        - entries held (0..2)
//               halted           - sticky, set once a halt payload is taken
//               bubble_cnt       - cycles downstream was ready but starved
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W  = 200,
    parameter int CNT_W   = STAGE_CNT_W,
    parameter int SKID_EN = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic [1:0]        occupancy,
    output logic              halted,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam bit              c_skid    = (SKID_EN != 0);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_halt;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_halt;
    logic              r_halted;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_main_halt_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_skid_halt_nxt;
    logic              w_halted_nxt;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_main_valid & out_ready;

    // A payload that arrives in a flush cycle is dropped, so it must not
    // be able to raise the halt flag either.
    assign w_halted_nxt = r_halted | (w_in_xfer & in_halt & ~flush);

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_halt_nxt  = r_main_halt;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_halt_nxt  = r_skid_halt;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_xfer) begin
            if (r_skid_valid) begin
                // in_ready is low whenever skid is full, so no input here.
                w_main_data_nxt  = r_skid_data;
                w_main_halt_nxt  = r_skid_halt;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_xfer) begin
                w_main_data_nxt = in_data;
                w_main_halt_nxt = in_halt;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_main_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
                w_main_halt_nxt  = in_halt;
            end else if (c_skid) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = in_data;
                w_skid_halt_nxt  = in_halt;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_halt  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_halt  <= 1'b0;
            r_halted     <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_halt  <= w_main_halt_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_halt  <= w_skid_halt_nxt;
            r_halted     <= w_halted_nxt;
            if (out_ready && !r_main_valid && !r_halted && r_bubble_cnt != c_cnt_max) begin
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
            end
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            // Registered ready: computed from next-state so that it has no
            // combinational dependency on out_ready.
            logic r_in_ready;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= ~w_skid_valid_nxt & ~w_halted_nxt;
                end
            end
            assign in_ready = r_in_ready;
        end else begin : g_single_ready
            assign in_ready = (out_ready | ~r_main_valid) & ~r_halted;
        end
    endgenerate

    assign out_valid  = r_main_valid;
    assign out_data   = r_main_data;
    assign out_halt   = r_main_valid & r_main_halt;
    assign occupancy  = occ_count(r_main_valid, r_skid_valid);
    assign halted     = r_halted;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed self-checking bench for pipe_stage_skid with a
//               scoreboard queue of expected payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DW = 200;

    typedef struct packed {
        logic          halt;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_halt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_halt;
    logic [1:0]    occupancy;
    logic          halted;
    logic [15:0]   bubble_cnt;

    logic          d2_in_ready;
    logic          d2_out_valid;
    logic [DW-1:0] d2_out_data;
    logic          d2_out_halt;
    logic [1:0]    d2_occupancy;
    logic          d2_halted;
    logic [1:0]    d2_bubble_cnt;
    logic [DW-1:0] d2_zero_data = '0;
    logic          d2_zero = 1'b0;

    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    int   n_before;
    ent_t sb[$];
    ent_t mon_e;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .SKID_EN(1)) dut (
        .CLK(clk), .RST(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
        .occupancy(occupancy), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(2), .SKID_EN(0)) dut_sat (
        .CLK(clk), .RST(rst), .flush(d2_zero),
        .in_valid(d2_zero), .in_ready(d2_in_ready), .in_data(d2_zero_data), .in_halt(d2_zero),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data), .out_halt(d2_out_halt),
        .occupancy(d2_occupancy), .halted(d2_halted), .bubble_cnt(d2_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic h);
        in_valid = v;
        in_data  = DW'(d);
        in_halt  = h;
    endtask

    // Scoreboard: pop on every output transfer, push on every accepted input.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_out: observed %0h expected none", out_data);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("sb_data", out_data, mon_e.data);
                    chk("sb_halt", DW'(out_halt), DW'(mon_e.halt));
                    n_out++;
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back('{in_halt, in_data});
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h0, 1'b0);
        step(); step();
        // Reset state
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_in_ready",  DW'(in_ready),  DW'(1));
        chk("rst_occ",       DW'(occupancy), DW'(0));
        chk("rst_bubble",    DW'(bubble_cnt), DW'(0));
        chk("rst_halted",    DW'(halted),    DW'(0));
        chk("rst_out_data",  out_data,       DW'(0));
        chk("rst_out_halt",  DW'(out_halt),  DW'(0));
        chk("rst_d2_valid",  DW'(d2_out_valid), DW'(0));
        chk("rst_d2_occ",    DW'(d2_occupancy), DW'(0));
        chk("rst_d2_halted", DW'(d2_halted),    DW'(0));
        chk("rst_d2_data",   d2_out_data,       DW'(0));
        chk("rst_d2_ohalt",  DW'(d2_out_halt),  DW'(0));
        rst = 1'b0;

        // Bubbles: 10 starved cycles
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("bubble_10",  DW'(bubble_cnt),    DW'(10));
        chk("bubble_sat", DW'(d2_bubble_cnt), DW'(3));
        chk("d2_in_ready", DW'(d2_in_ready),  DW'(1));

        // Streaming 1..8 back-to-back
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
            chk("stream_valid", DW'(out_valid), DW'(1));
            chk("stream_data",  out_data,       DW'(i));
            chk("stream_occ",   DW'(occupancy), DW'(1));
            chk("stream_rdy",   DW'(in_ready),  DW'(1));
        end
        drive(1'b0, 8'h0, 1'b0);
        step();
        chk("stream_drain", DW'(out_valid), DW'(0));
        chk("stream_count", DW'(n_out), DW'(8));

        // Backpressure: A, B accepted, C held
        out_ready = 1'b0;
        drive(1'b1, 8'hA, 1'b0); step();
        chk("bp_occ1", DW'(occupancy), DW'(1));
        drive(1'b1, 8'hB, 1'b0); step();
        chk("bp_occ2", DW'(occupancy), DW'(2));
        chk("bp_rdy0", DW'(in_ready),  DW'(0));
        drive(1'b1, 8'hC, 1'b0); step();
        chk("bp_hold_occ",  DW'(occupancy), DW'(2));
        chk("bp_hold_rdy",  DW'(in_ready),  DW'(0));
        chk("bp_hold_data", out_data,       DW'(8'hA));
        out_ready = 1'b1;
        step();
        chk("bp_head_b", out_data,      DW'(8'hB));
        chk("bp_rdy1",   DW'(in_ready), DW'(1));
        step();
        chk("bp_head_c", out_data, DW'(8'hC));
        drive(1'b0, 8'h0, 1'b0);
        step();
        chk("bp_empty", DW'(out_valid), DW'(0));
        chk("bp_count", DW'(n_out),     DW'(11));

        // Flush with full stage and pending 0xD
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0); step();
        drive(1'b1, 8'h12, 1'b0); step();
        drive(1'b1, 8'hD, 1'b0); flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h0, 1'b0);
        chk("fl_occ",   DW'(occupancy), DW'(0));
        chk("fl_valid", DW'(out_valid), DW'(0));
        out_ready = 1'b1;
        step(); step();
        chk("fl_rdy",   DW'(in_ready), DW'(1));
        chk("fl_none",  DW'(n_out),    DW'(11));

        // Flush while the head is consumed
        out_ready = 1'b0;
        drive(1'b1, 8'h21, 1'b0); step();
        drive(1'b1, 8'h22, 1'b0); step();
        drive(1'b0, 8'h0, 1'b0);
        n_before = n_out;
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl2_occ",  DW'(occupancy),        DW'(0));
        step(); step();
        chk("fl2_once", DW'(n_out - n_before), DW'(1));

        // Reset mid-transfer
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 1'b0); step();
        drive(1'b1, 8'h32, 1'b0); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 8'h0, 1'b0);
        chk("mrst_occ",    DW'(occupancy),  DW'(0));
        chk("mrst_valid",  DW'(out_valid),  DW'(0));
        chk("mrst_rdy",    DW'(in_ready),   DW'(1));
        chk("mrst_bubble", DW'(bubble_cnt), DW'(0));
        chk("mrst_data",   out_data,        DW'(0));

        // Halt
        drive(1'b1, 8'h5, 1'b0); step();
        drive(1'b1, 8'h6, 1'b1); step();
        chk("h_halted", DW'(halted),    DW'(1));
        chk("h_rdy",    DW'(in_ready),  DW'(0));
        chk("h_occ",    DW'(occupancy), DW'(2));
        drive(1'b1, 8'h7, 1'b0); step();
        chk("h_block_occ", DW'(occupancy), DW'(2));
        chk("h_head5",     out_data,       DW'(8'h5));
        chk("h_ohalt5",    DW'(out_halt),  DW'(0));
        out_ready = 1'b1;
        step();
        chk("h_head6",  out_data,       DW'(8'h6));
        chk("h_ohalt6", DW'(out_halt),  DW'(1));
        chk("h_occ1",   DW'(occupancy), DW'(1));
        step();
        chk("h_drained", DW'(occupancy), DW'(0));
        chk("h_rdy_low", DW'(in_ready),  DW'(0));
        drive(1'b0, 8'h0, 1'b0);
        step(); step();
        chk("h_no_bubble", DW'(bubble_cnt), DW'(0));
        flush = 1'b1; step(); flush = 1'b0;
        chk("h_sticky", DW'(halted), DW'(1));
        chk("h_sb_empty", DW'(sb.size()), DW'(0));
        rst = 1'b1; out_ready = 1'b0; step(); rst = 1'b0;
        chk("h_rst_clear", DW'(halted),   DW'(0));
        chk("h_rst_rdy",   DW'(in_ready), DW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
